// File: rtl/exprom_pkg.sv
// Shared types and defaults for the expansion-ROM target controller.
package exprom_pkg;

    localparam int          ROM_AW    = 9;
    localparam logic [31:0] FILL_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    // Byte-lane merge for partial writes: enabled lanes take new data.
    function automatic logic [31:0] lane_merge(input logic [3:0]  be,
                                               input logic [31:0] wdata,
                                               input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/exprom_rsp_fifo.sv
// Two-entry valid/ready read-response buffer with occupancy output.
module exprom_rsp_fifo (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_valid,
    input  logic [31:0] push_data,
    output logic        pop_valid,
    input  logic        pop_ready,
    output logic [31:0] pop_data,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        pop;

    assign pop       = pop_valid & pop_ready;
    assign pop_valid = (count != 2'd0);
    assign pop_data  = mem[rd_ptr];

    // Push into a full buffer only happens together with a pop of the same slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_valid) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/exprom_ctrl.sv
// Expansion-ROM target controller: read streaming through a response buffer,
// full-word writes, read-modify-write for partial writes, locked-write drop counter.
module exprom_ctrl #(
    parameter int          ROM_AW    = exprom_pkg::ROM_AW,
    parameter logic [31:0] FILL_DATA = exprom_pkg::FILL_DATA
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ROM_AW-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    input  logic              rom_decode,
    input  logic              wr_unlock,
    output logic [ROM_AW-1:0] rom_address,
    output logic              rom_enable,
    output logic              rom_wren,
    output logic [31:0]       rom_dinp,
    input  logic [31:0]       rom_dout,
    output logic [7:0]        wr_drop_cnt,
    output logic [1:0]        state_dbg
);
    import exprom_pkg::*;

    // Handshakes: a request moves on a clock edge where req_valid & req_ready;
    // a response moves where rsp_valid & rsp_ready. Neither side may retract
    // valid before the transfer, and rsp_data holds while stalled.

    state_t      state;
    logic        rdy_en;
    logic        inflight;
    logic        inflight_fill;
    logic [3:0]  rmw_be;
    logic [31:0] rmw_data;
    logic [1:0]  buf_count;
    logic [1:0]  occ;
    logic        buf_pop;
    logic        acc;

    assign buf_pop   = rsp_valid & rsp_ready;
    // Credit counts the read still in the array and returns the slot popped this cycle.
    assign occ       = buf_count + {1'b0, inflight} - {1'b0, buf_pop};
    assign acc       = req_valid & req_ready;
    assign state_dbg = state;

    always_comb begin
        req_ready = 1'b0;
        if (rdy_en && state == IDLE) begin
            if (!req_write)                        req_ready = (occ < 2'd2);
            else if (wr_unlock && req_be == 4'hF)  req_ready = !inflight;
            else                                   req_ready = 1'b1;
        end
    end

    exprom_rsp_fifo u_rsp_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (inflight),
        .push_data  (inflight_fill ? FILL_DATA : rom_dout),
        .pop_valid  (rsp_valid),
        .pop_ready  (rsp_ready),
        .pop_data   (rsp_data),
        .count      (buf_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rdy_en        <= 1'b0;
            inflight      <= 1'b0;
            inflight_fill <= 1'b0;
            rmw_be        <= '0;
            rmw_data      <= '0;
            rom_address   <= '0;
            rom_enable    <= 1'b0;
            rom_wren      <= 1'b0;
            rom_dinp      <= '0;
            wr_drop_cnt   <= '0;
        end else begin
            rdy_en     <= 1'b1;
            rom_enable <= 1'b0;
            rom_wren   <= 1'b0;
            inflight   <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (!req_write) begin
                            inflight      <= 1'b1;
                            inflight_fill <= !rom_decode;
                            rom_address   <= req_addr;
                            rom_enable    <= rom_decode;
                        end else if (req_be == 4'h0) begin
                            // empty write: accepted and discarded
                        end else if (!wr_unlock) begin
                            if (wr_drop_cnt != 8'hFF) wr_drop_cnt <= wr_drop_cnt + 8'd1;
                        end else if (req_be == 4'hF) begin
                            rom_address <= req_addr;
                            rom_enable  <= 1'b1;
                            rom_wren    <= 1'b1;
                            rom_dinp    <= req_wdata;
                        end else begin
                            rom_address <= req_addr;
                            rom_enable  <= 1'b1;
                            rmw_be      <= req_be;
                            rmw_data    <= req_wdata;
                            state       <= RMW_RD;
                        end
                    end
                end
                RMW_RD: begin
                    rom_dinp   <= lane_merge(rmw_be, rmw_data, rom_dout);
                    rom_enable <= 1'b1;
                    rom_wren   <= 1'b1;
                    state      <= RMW_WR;
                end
                RMW_WR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
